// File: rtl/fpu_defs_fmac.sv
// Shared FMAC datapath widths.
package fpu_defs_fmac;
  localparam int unsigned C_FMAC_MANT      = 23;
  localparam int unsigned C_FMAC_LZA_WIDTH = 3 * C_FMAC_MANT + 5;
  localparam int unsigned C_FMAC_SHAMT_W   = $clog2(C_FMAC_LZA_WIDTH);
  localparam int unsigned C_FMAC_EXP_W     = 10;
endpackage

// File: rtl/fmac_lzc.sv
// Leading-zero counter built as a tree of 2:1 priority merges.
module fmac_lzc #(
  parameter int unsigned WIDTH = 74,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  localparam int unsigned NP  = 1 << CNT_W;
  localparam int unsigned PAD = NP - WIDTH;

  // Trailing ones make an all-zero input count to exactly WIDTH.
  logic [NP-1:0]    padded;
  logic             node_v [CNT_W+1][NP];
  logic [CNT_W-1:0] node_c [CNT_W+1][NP];

  assign padded = {in_vec, {PAD{1'b1}}};

  always_comb begin
    for (int k = 0; k <= int'(CNT_W); k++) begin
      for (int j = 0; j < int'(NP); j++) begin
        node_v[k][j] = 1'b0;
        node_c[k][j] = '0;
      end
    end
    for (int j = 0; j < int'(NP); j++) begin
      node_v[0][j] = padded[NP-1-j];
    end
    // Left child is the more significant half; it wins when it holds a one.
    for (int k = 1; k <= int'(CNT_W); k++) begin
      for (int i = 0; i < int'(NP >> k); i++) begin
        node_v[k][i] = node_v[k-1][2*i] | node_v[k-1][2*i+1];
        node_c[k][i] = node_v[k-1][2*i] ? node_c[k-1][2*i]
                     : CNT_W'((1 << (k - 1)) + int'(node_c[k-1][2*i+1]));
      end
    end
  end

  assign cnt  = node_c[CNT_W][0];
  assign zero = ~|in_vec;
endmodule

// File: rtl/fmac_lza_norm.sv
// FMAC LZA predict + one-step correction normaliser, two-stage valid/ready pipeline.
module fmac_lza_norm
  import fpu_defs_fmac::*;
#(
  parameter int unsigned C_WIDTH   = C_FMAC_LZA_WIDTH,
  parameter int unsigned C_EXP_W   = C_FMAC_EXP_W,
  parameter int unsigned C_SHAMT_W = C_FMAC_SHAMT_W
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 Flush_SI,
  input  logic                 Valid_SI,
  output logic                 Ready_SO,
  input  logic [C_WIDTH-1:0]   Sum_pos_DI,
  input  logic [C_WIDTH-1:0]   A_LZA_DI,
  input  logic [C_WIDTH-1:0]   B_LZA_DI,
  input  logic                 Sign_DI,
  input  logic [C_EXP_W-1:0]   Exp_DI,
  output logic                 Valid_SO,
  input  logic                 Ready_SI,
  output logic [C_WIDTH-1:0]   Mant_norm_DO,
  output logic [C_EXP_W-1:0]   Exp_norm_DO,
  output logic [C_SHAMT_W-1:0] Shamt_DO,
  output logic                 Sign_DO,
  output logic                 Zero_SO,
  output logic                 Lza_miss_SO
);
  localparam int unsigned P_W = $clog2(C_WIDTH + 1);

  logic [C_WIDTH-1:0]   lza_or;
  logic [P_W-1:0]       p;
  logic                 or_zero;
  logic [C_SHAMT_W-1:0] s1;
  logic                 clear, load1, load2;
  logic                 v1, v2;
  logic [C_WIDTH-1:0]   m1, m2, m2_nxt;
  logic [C_SHAMT_W-1:0] sh1, sh2, sh2_nxt;
  logic [C_EXP_W-1:0]   e1, e2, e2_nxt;
  logic                 sg1, sg2, z1, z2, miss2, miss2_nxt, corr;

  assign lza_or = A_LZA_DI | B_LZA_DI;

  fmac_lzc #(.WIDTH(C_WIDTH), .CNT_W(P_W)) u_lzc (
    .in_vec(lza_or),
    .cnt   (p),
    .zero  (or_zero)
  );

  // Pre-shift one less than the prediction so the correction only ever shifts left.
  always_comb begin
    s1 = '0;
    if (or_zero)        s1 = C_SHAMT_W'(C_WIDTH - 1);
    else if (p != '0)   s1 = C_SHAMT_W'(p - 1'b1);
  end

  assign clear    = Rst_RI | Flush_SI;
  assign load2    = ~v2 | Ready_SI;
  assign load1    = ~v1 | load2;
  assign Ready_SO = ~clear & load1;

  always_ff @(posedge Clk_CI) begin
    if (clear) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (load1) v1 <= Valid_SI;
      if (load2) v2 <= v1;
    end
  end

  always_comb begin
    corr      = ~m1[C_WIDTH-1] & ~z1;
    m2_nxt    = z1 ? '0 : (corr ? (m1 << 1) : m1);
    sh2_nxt   = z1 ? '0 : sh1 + C_SHAMT_W'(corr);
    e2_nxt    = e1 - C_EXP_W'(sh2_nxt);
    miss2_nxt = ~z1 & ~m2_nxt[C_WIDTH-1];
  end

  // Payload registers only move on advance; no reset needed.
  always_ff @(posedge Clk_CI) begin
    if (load1 && Valid_SI && !clear) begin
      m1  <= Sum_pos_DI << s1;
      sh1 <= s1;
      e1  <= Exp_DI;
      sg1 <= Sign_DI;
      z1  <= ~|Sum_pos_DI;
    end
    if (load2 && v1 && !clear) begin
      m2    <= m2_nxt;
      sh2   <= sh2_nxt;
      e2    <= e2_nxt;
      sg2   <= sg1;
      z2    <= z1;
      miss2 <= miss2_nxt;
    end
  end

  // Data outputs read as zero whenever no beat is presented.
  assign Valid_SO     = v2;
  assign Mant_norm_DO = v2 ? m2 : '0;
  assign Shamt_DO     = v2 ? sh2 : '0;
  assign Exp_norm_DO  = v2 ? e2 : '0;
  assign Sign_DO      = v2 & sg2;
  assign Zero_SO      = v2 & z2;
  assign Lza_miss_SO  = v2 & miss2;
endmodule

// File: tb/tb_fmac_lza_norm.sv
// Self-checking bench: spec-level model + scoreboard, plus directed literal vectors.
module tb_fmac_lza_norm;
  localparam int unsigned W  = 74;
  localparam int unsigned EW = 10;
  localparam int unsigned SW = 7;

  logic          clk, rst, flush, vin, rdy_out, vout, rdy_in;
  logic [W-1:0]  sum, a, b, mant;
  logic          sg, sg_o, zero_o, miss_o;
  logic [EW-1:0] ex, ex_o;
  logic [SW-1:0] sh_o;

  fmac_lza_norm dut (
    .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush), .Valid_SI(vin), .Ready_SO(rdy_out),
    .Sum_pos_DI(sum), .A_LZA_DI(a), .B_LZA_DI(b), .Sign_DI(sg), .Exp_DI(ex),
    .Valid_SO(vout), .Ready_SI(rdy_in), .Mant_norm_DO(mant), .Exp_norm_DO(ex_o),
    .Shamt_DO(sh_o), .Sign_DO(sg_o), .Zero_SO(zero_o), .Lza_miss_SO(miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  mant;
    logic [SW-1:0] sh;
    logic [EW-1:0] e;
    logic          sg;
    logic          z;
    logic          miss;
  } beat_t;

  beat_t q[$];
  int passed = 0;
  int total  = 0;
  int pops   = 0;

  // Predict from the OR's leading zeros, back off by one, fix up one slip.
  function automatic beat_t model(input logic [W-1:0] s, input logic [W-1:0] oa,
                                  input logic [W-1:0] ob, input logic isg, input logic [EW-1:0] ie);
    beat_t r;
    logic [W-1:0] orv, m;
    int pz, amt;
    orv = oa | ob;
    pz = int'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (orv[W-1-i]) begin pz = i; break; end
    end
    r.sg = isg;
    if (s == '0) begin
      r.mant = '0; r.sh = '0; r.e = ie; r.z = 1'b1; r.miss = 1'b0;
    end else begin
      amt = (pz == 0) ? 0 : pz - 1;
      if (amt > int'(W) - 1) amt = int'(W) - 1;
      m = s << amt;
      if (!m[W-1]) begin m = m << 1; amt = amt + 1; end
      r.mant = m; r.sh = SW'(amt); r.e = ie - EW'(amt); r.z = 1'b0; r.miss = ~m[W-1];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard: every presented output beat must match the oldest accepted input.
  always @(negedge clk) begin
    beat_t e;
    if (vout === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got output mant %0h expected no beat", mant);
      end else begin
        e = q[0];
        check("sb_mant", 128'(mant), 128'(e.mant));
        check("sb_shamt", 128'(sh_o), 128'(e.sh));
        check("sb_exp", 128'(ex_o), 128'(e.e));
        check("sb_sign", 128'(sg_o), 128'(e.sg));
        check("sb_zero", 128'(zero_o), 128'(e.z));
        check("sb_miss", 128'(miss_o), 128'(e.miss));
      end
    end
    if (rst || flush) q.delete();
    else begin
      if (vout && rdy_in && q.size() > 0) begin void'(q.pop_front()); pops++; end
      if (vin && rdy_out) q.push_back(model(sum, a, b, sg, ex));
    end
  end

  task automatic drive(input logic [W-1:0] s, input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dsg, input logic [EW-1:0] de);
    vin = 1'b1; sum = s; a = da; b = db; sg = dsg; ex = de;
  endtask

  task automatic send_one(input string name, input logic [W-1:0] s, input logic [W-1:0] da,
                          input logic [W-1:0] db, input logic dsg, input logic [EW-1:0] de,
                          input logic [W-1:0] xm, input logic [SW-1:0] xsh, input logic [EW-1:0] xe,
                          input logic xz, input logic xmiss);
    @(posedge clk); #1 drive(s, da, db, dsg, de);
    @(posedge clk); #1 vin = 1'b0;
    @(negedge clk);
    check({name, "_lat1_valid"}, 128'(vout), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_valid"}, 128'(vout), 128'(1));
    check({name, "_mant"}, 128'(mant), 128'(xm));
    check({name, "_shamt"}, 128'(sh_o), 128'(xsh));
    check({name, "_exp"}, 128'(ex_o), 128'(xe));
    check({name, "_sign"}, 128'(sg_o), 128'(dsg));
    check({name, "_zero"}, 128'(zero_o), 128'(xz));
    check({name, "_miss"}, 128'(miss_o), 128'(xmiss));
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, 128'(vout), 128'(0));
    check({name, "_ready"}, 128'(rdy_out), 128'(1));
    check({name, "_mant"}, 128'(mant), 128'(0));
    check({name, "_shamt"}, 128'(sh_o), 128'(0));
    check({name, "_exp"}, 128'(ex_o), 128'(0));
    check({name, "_flags"}, 128'({sg_o, zero_o, miss_o}), 128'(0));
  endtask

  logic [W-1:0] top, snap, ra, rb;
  beat_t mr;
  int pops0;
  logic acc;

  initial begin
    top = W'(1) << (W - 1);
    rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    sum = '0; a = '0; b = '0; sg = 1'b0; ex = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Pin the model against hand-derived values.
    mr = model(W'(1), '0, W'(1), 1'b0, EW'(100));
    check("model_lsb_shamt", 128'(mr.sh), 128'(73));
    mr = model(W'(1) << 40, W'(1) << 40, '0, 1'b0, '0);
    check("model_corr_shamt", 128'(mr.sh), 128'(33));

    send_one("msb",   top, top, '0, 1'b0, EW'(5), top, SW'(0), EW'(5), 1'b0, 1'b0);
    send_one("lsb",   W'(1), '0, W'(1), 1'b1, EW'(100), top, SW'(73), EW'(27), 1'b0, 1'b0);
    send_one("nocorr", W'(1) << 41, W'(1) << 40, W'(1) << 40, 1'b0, EW'(50), top, SW'(32), EW'(18), 1'b0, 1'b0);
    send_one("corr",  W'(1) << 40, W'(1) << 40, '0, 1'b1, EW'(0), top, SW'(33), EW'(10'h3DF), 1'b0, 1'b0);
    send_one("zero",  '0, '0, '0, 1'b0, EW'(10'h3FD), '0, SW'(0), EW'(10'h3FD), 1'b1, 1'b0);
    send_one("miss",  W'(1), top, '0, 1'b0, EW'(10), W'(2), SW'(1), EW'(9), 1'b0, 1'b1);

    // Backpressure: two beats fill the pipe, third is stalled.
    @(posedge clk); #1 rdy_in = 1'b0; pops0 = pops;
    drive(W'(3) << 20, W'(3) << 20, '0, 1'b0, EW'(1));
    @(posedge clk); #1 drive(W'(5) << 60, W'(4) << 60, W'(1) << 60, 1'b1, EW'(2));
    @(posedge clk); #1 drive(W'(7), W'(4), W'(3), 1'b0, EW'(3));
    @(negedge clk);
    check("bp_ready_drop", 128'(rdy_out), 128'(0));
    snap = mant;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_stall_valid", 128'(vout), 128'(1));
      check("bp_stall_mant", 128'(mant), 128'(snap));
      check("bp_stall_ready", 128'(rdy_out), 128'(0));
    end
    rdy_in = 1'b1;
    @(posedge clk); #1 drive(W'(9) << 30, W'(8) << 30, W'(1) << 30, 1'b1, EW'(4));
    @(posedge clk); #1 vin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_beats_out", 128'(pops - pops0), 128'(4));
    check("bp_queue_empty", 128'(q.size()), 128'(0));

    // Flush mid-stream, with a beat offered during the flush.
    @(posedge clk); #1 drive(W'(1) << 10, W'(1) << 10, '0, 1'b0, EW'(7));
    @(posedge clk); #1 drive(W'(1) << 11, W'(1) << 11, '0, 1'b0, EW'(8));
    @(posedge clk); #1 flush = 1'b1; drive(W'(1) << 12, W'(1) << 12, '0, 1'b0, EW'(9));
    @(negedge clk);
    check("flush_ready", 128'(rdy_out), 128'(0));
    @(posedge clk); #1 flush = 1'b0; vin = 1'b0;
    @(negedge clk);
    check("flush_valid", 128'(vout), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_no_capture", 128'(vout), 128'(0));

    // Reset mid-stream.
    @(posedge clk); #1 drive(W'(1) << 50, W'(1) << 50, '0, 1'b1, EW'(7));
    @(posedge clk); #1 drive(W'(1) << 51, W'(1) << 51, '0, 1'b1, EW'(8));
    @(posedge clk); #1 rst = 1'b1; vin = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("midrst");

    // Exact LZA operand pairs with random backpressure.
    for (int i = 0; i < 10; i++) begin
      ra = W'({$urandom, $urandom, $urandom}) >> $urandom_range(2, 73);
      rb = W'({$urandom, $urandom, $urandom}) >> $urandom_range(2, 73);
      drive(ra + rb, ra, rb, i[0], EW'($urandom));
      acc = 1'b0;
      for (int c = 0; c < 30; c++) begin
        rdy_in = 1'($urandom_range(0, 1));
        @(negedge clk); acc = rdy_out;
        @(posedge clk); #1;
        if (acc) break;
      end
      if (!acc) begin total++; $display("FAIL rand_accept_timeout: got no accept expected accept"); end
    end
    vin = 1'b0; rdy_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_queue_empty", 128'(q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fmac_lza_norm.md
# fmac_lza_norm

Pipelined leading-zero anticipation and normalisation stage of the FMAC datapath, directly downstream of the end-around-carry adders. It takes the positive sum magnitude, the LZA operand pair, the result sign and the pre-normalisation exponent. It predicts the leading-zero count from the LZA operands, left-shifts the sum to bring its MSB to bit `C_WIDTH-1`, and corrects a one-position misprediction. It hands the normalised mantissa, the adjusted exponent and the flags to the rounding stage over a valid/ready handshake with 2-cycle latency.

## Interface
- `C_WIDTH`, default 74 (`3*C_FMAC_MANT+5`): width of the sum and LZA operands.
- `C_EXP_W`, default 10: signed exponent width.
- `C_SHAMT_W`, default 7: shift-amount width, `$clog2(C_WIDTH)`.
- `Clk_CI`  in  1  clock; one clock domain.
- `Rst_RI`  in  1  reset, synchronous, active-high.
- `Flush_SI`  in  1  synchronous pipeline clear.
- `Valid_SI`  in  1  input beat valid.
- `Ready_SO`  out  1  stage can accept the input beat.
- `Sum_pos_DI`  in  `C_WIDTH`  positive sum magnitude.
- `A_LZA_DI`  in  `C_WIDTH`  LZA operand A.
- `B_LZA_DI`  in  `C_WIDTH`  LZA operand B.
- `Sign_DI`  in  1  result sign.
- `Exp_DI`  in  `C_EXP_W`  signed pre-normalisation exponent.
- `Valid_SO`  out  1  output beat valid.
- `Ready_SI`  in  1  downstream accepts.
- `Mant_norm_DO`  out  `C_WIDTH`  normalised mantissa.
- `Exp_norm_DO`  out  `C_EXP_W`  `Exp_DI - Shamt_DO`, two's complement, wraps modulo 2^`C_EXP_W`.
- `Shamt_DO`  out  `C_SHAMT_W`  total left-shift applied.
- `Sign_DO`  out  1  sign, passed through.
- `Zero_SO`  out  1  `Sum_pos_DI` was all zero.
- `Lza_miss_SO`  out  1  `Mant_norm_DO[C_WIDTH-1]` is 0 while `Zero_SO` is 0.

## Operation
- Stage 1 (predict):
  - P = leading-zero count of (`A_LZA_DI | B_LZA_DI`); all-zero OR gives P = `C_WIDTH`.
  - Pre-shift S1 = (P==0) ? 0 : P-1, saturated to `C_WIDTH-1`.
  - Register `Sum_pos_DI << S1`, S1, sign, exponent and Zero (= `Sum_pos_DI==0`).
- Stage 2 (correct):
  - If the registered mantissa MSB is 0 and Zero is 0, shift left by one more and add 1 to the shift amount.
  - Otherwise pass the mantissa through unchanged.
  - Register the result as Mant, Shamt, Exp_norm and the flags.
- Exactness: for nonnegative A and B with Sum = A+B, true lzc ∈ {P-1, P}, so Shamt = lzc(Sum) and the output MSB is 1.
- Miss: a prediction outside that window is not corrected further; `Lza_miss_SO` flags it and the mantissa is output as shifted.
- Zero: when Zero=1, force Mant=0, Shamt=0, Exp_norm=`Exp_DI`, `Lza_miss_SO`=0.
- Handshake, per stage register (valid bit plus payload):
  - A stage loads when it is empty or its contents are leaving.
  - Stage 2 leaves on `Valid_SO & Ready_SI`.
  - `Ready_SO = ~V1 | ~V2 | Ready_SI`, where V1 and V2 are the stage valid bits.
  - A stage holds its payload stable while its valid is high and it cannot advance.
  - Payload registers load only on advance; valid bits are the only reset state.

## Timing
- Latency is 2 cycles from accepted input to `Valid_SO` with no backpressure. Throughput is 1 beat per cycle.
- Reset (`Rst_RI`) and `Flush_SI` clear V1 and V2 at the next edge, including mid-operation, discarding in-flight beats.
  - While either is asserted, input is not captured.
  - Reset values: `Valid_SO`=0, `Ready_SO`=1 from the first cycle after reset, all data outputs 0.
- Full pipeline with `Ready_SI`=0: `Ready_SO`=0, both stages hold, outputs stable.
- Full pipeline with `Ready_SI` going high: in the same cycle stage 2 drains, stage 1 moves to stage 2, and a new input is accepted.
- Flush together with `Ready_SI`: the flush wins and no beat is reported accepted.

## Structure
- The `fpu_defs_fmac` package holds `C_FMAC_MANT`, `C_FMAC_LZA_WIDTH`(74), `C_FMAC_SHAMT_W`(7) and `C_FMAC_EXP_W`.
- Sub-module `fmac_lzc`:
  - Parameterised leading-zero counter producing a count and an all-zero flag.
  - Tree of 2:1 priority merges.
  - Used once for P.

## Test plan
- Sum=1<<73, A=1<<73, B=0, Exp=5 → 2 cycles later Mant=1<<73, Shamt=0, Exp_norm=5, miss=0.
- Sum=1, A=0, B=1 → Shamt=73, Mant=1<<73, Exp_norm=`Exp_DI`-73.
- A=B=1<<40, Sum=1<<41 → P=33, S1=32, no correction; Shamt=32, Mant=1<<73.
- A=1<<40, B=0, Sum=1<<40 → S1=32, correction fires, Shamt=33.
- Sum=0, A=B=0, Exp=-3 → Zero=1, Mant=0, Shamt=0, Exp_norm=-3.
- Backpressure and flush:
  - Stream 4 beats with `Ready_SI` low for 3 cycles → `Ready_SO` drops after 2 beats and outputs stay stable; beats leave in order with none lost or duplicated.
  - `Flush_SI` mid-stream → `Valid_SO`=0 next cycle.
  - `Rst_RI` mid-stream → same outputs as after a fresh reset.
